alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single 32-bit combinational ALU between two requesters, e.g. the VGA pixel-address generator and the CPU-side coprocessor port. Each requester issues one operation (operands plus 3-bit ALU control) with a valid/ready handshake. The block grants requesters round-robin, drives the shared ALU from registered operands, and returns the captured result and overflow flag on a per-requester response channel with backpressure.

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered before reaching the ALU; results return on per-port response channels.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_of,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_of,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_of
);

  // state | meaning
  // IDLE  | waiting for a request; grant goes to the lone valid port or to prio on a tie
  // EXEC  | registered operands drive the ALU; result captured at the end of this cycle
  // RESP  | result held on the owner's response channel until it is consumed
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             prio, prio_nxt;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [2:0]       op_ctl;
  logic             res_of;

  // grant == 1 selects requester 1
  assign grant  = (req0_valid && req1_valid) ? prio : req1_valid;
  assign accept = req0_ready | req1_ready;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    prio_nxt   = prio;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          req0_ready = req0_valid & ~grant;
          req1_ready = req1_valid & grant;
          if (req0_ready || req1_ready) begin
            state_nxt = EXEC;
            owner_nxt = grant;
          end
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (!reset) begin
          rsp0_valid = ~owner;
          rsp1_valid = owner;
          if (owner ? rsp1_ready : rsp0_ready) begin
            prio_nxt  = ~owner;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      prio   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_ctl <= 3'b000;
      res    <= '0;
      res_of <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
      if (accept) begin
        op_a   <= grant ? req1_a  : req0_a;
        op_b   <= grant ? req1_b  : req0_b;
        op_ctl <= grant ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        res    <= alu_result;
        // overflow only carries meaning for add and sub
        res_of <= ((op_ctl == OP_ADD) || (op_ctl == OP_SUB)) ? alu_of : 1'b0;
      end
    end
  end

  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_control = op_ctl;

  assign rsp0_result = res;
  assign rsp1_result = res;
  assign rsp0_of     = res_of;
  assign rsp1_of     = res_of;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_of, rsp1_valid, rsp1_ready, rsp1_of;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_of;

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_of(rsp0_of),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_of(rsp1_of),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result), .alu_of(alu_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared combinational ALU
  always_comb begin
    logic [32:0] t;
    t = '0;
    alu_result = '0;
    alu_of = 1'b0;
    case (alu_control)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~(alu_a | alu_b);
      3'b010: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = t[31:0];
        alu_of = (alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]);
      end
      3'b110: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = t[31:0];
        alu_of = (alu_a[31] != alu_b[31]) && (t[31] != alu_a[31]);
      end
      3'b111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      3'b011: alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  // expected {of, result} of an operation from plain integer arithmetic
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb, s;
    logic [31:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0;
    o = 1'b0;
    r = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~(a | b);
      3'b010: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b110: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      3'b011: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: one in-flight transaction, its age in cycles since accept
  logic        m_busy, m_owner, m_prio, m_shown_of, m_pof;
  int          m_age;
  logic [31:0] m_a, m_b, m_shown, m_pres;
  logic [2:0]  m_op;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_prio = 0; m_age = 0;
    m_a = 0; m_b = 0; m_op = 0; m_shown = 0; m_shown_of = 0; m_pres = 0; m_pof = 0;
  endtask

  always @(negedge clk) begin
    logic e_r0, e_r1, e_v0, e_v1;
    if (mon_on) begin
      e_r0 = !reset && !m_busy && req0_valid && (!req1_valid || !m_prio);
      e_r1 = !reset && !m_busy && req1_valid && (!req0_valid || m_prio);
      e_v0 = !reset && m_busy && (m_age >= 2) && !m_owner;
      e_v1 = !reset && m_busy && (m_age >= 2) && m_owner;
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, e_r0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, e_r1});
      chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, e_v0});
      chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e_v1});
      chk("rsp0_result", rsp0_result, m_shown);
      chk("rsp1_result", rsp1_result, m_shown);
      chk("rsp0_of", {31'b0, rsp0_of}, {31'b0, m_shown_of});
      chk("rsp1_of", {31'b0, rsp1_of}, {31'b0, m_shown_of});
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_control", {29'b0, alu_control}, {29'b0, m_op});
      if (reset) model_reset();
      else if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_busy = 1; m_owner = e_r1; m_age = 1;
          m_a  = e_r1 ? req1_a  : req0_a;
          m_b  = e_r1 ? req1_b  : req0_b;
          m_op = e_r1 ? req1_op : req0_op;
          {m_pof, m_pres} = ref_alu(m_a, m_b, m_op);
        end
      end else if (m_age == 1) begin
        m_age = 2; m_shown = m_pres; m_shown_of = m_pof;
      end else if (m_owner ? rsp1_ready : rsp0_ready) begin
        m_busy = 0; m_prio = !m_owner;
      end
    end
  end

  task automatic set_req(input int port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (port == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  // called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n;
    logic got;
    set_req(port, a, b, op);
    got = 0;
    for (n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (port == 0) ? req0_ready : req1_ready;
    end
    if (!got) begin bad++; total++; $display("FAIL accept_timeout: port %0d never ready", port); end
    @(posedge clk); #1;
    if (port == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // waits for the response, checks it, consumes it; returns at posedge+1 after the handshake edge
  task automatic wait_rsp(input int port, input logic [31:0] er, input logic eof, input int hold, input string nm);
    int n;
    logic got;
    logic [31:0] r0;
    if (hold == 0) begin if (port == 0) rsp0_ready = 1; else rsp1_ready = 1; end
    got = 0;
    n = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      got = (port == 0) ? rsp0_valid : rsp1_valid;
    end
    if (!got) begin
      bad++; total++; $display("FAIL %s_timeout: no response on port %0d", nm, port);
    end else begin
      chk({nm, "_latency"}, n, 2);
      r0 = (port == 0) ? rsp0_result : rsp1_result;
      chk({nm, "_result"}, r0, er);
      chk({nm, "_of"}, {31'b0, (port == 0) ? rsp0_of : rsp1_of}, {31'b0, eof});
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({nm, "_held_valid"}, {31'b0, (port == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
        chk({nm, "_held_result"}, (port == 0) ? rsp0_result : rsp1_result, er);
        chk({nm, "_other_ready"}, {31'b0, (port == 0) ? req1_ready : req0_ready}, 32'd0);
      end
      if (hold != 0) begin
        @(posedge clk); #1;
        if (port == 0) rsp0_ready = 1; else rsp1_ready = 1;
      end
    end
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic h0, h1;
    reset = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    model_reset();

    chk("ref_add", ref_alu(32'd5, 32'd7, 3'b010), {1'b0, 32'd12});
    chk("ref_sub_of", ref_alu(32'h8000_0000, 32'd1, 3'b110), {1'b1, 32'h7FFF_FFFF});
    chk("ref_slt", ref_alu(32'hFFFF_FFFF, 32'd1, 3'b111), {1'b0, 32'd1});
    chk("ref_sltu", ref_alu(32'hFFFF_FFFF, 32'd1, 3'b011), {1'b0, 32'd0});

    @(posedge clk); #1 mon_on = 1;
    @(posedge clk); #1 reset = 0;

    // single add and a few single-port operations
    issue(0, 32'd5, 32'd7, 3'b010);
    wait_rsp(0, 32'd12, 1'b0, 0, "add");
    issue(1, 32'h8000_0000, 32'd1, 3'b110);
    wait_rsp(1, 32'h7FFF_FFFF, 1'b1, 0, "sub_of");
    issue(1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'b000);
    wait_rsp(1, 32'h0F0F_0F0F, 1'b0, 0, "and");
    issue(0, 32'hFFFF_FFFF, 32'd1, 3'b011);
    wait_rsp(0, 32'd0, 1'b0, 0, "sltu");
    issue(0, 32'd0, 32'd0, 3'b101);
    wait_rsp(0, 32'hFFFF_FFFF, 1'b0, 0, "nor");

    // contention from reset, twice
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    for (int rep = 0; rep < 2; rep++) begin
      set_req(0, 32'd1, 32'd1, 3'b010);
      set_req(1, 32'hFF, 32'h0F, 3'b100);
      @(negedge clk);
      chk("tie_ready0", {31'b0, req0_ready}, 32'd1);
      chk("tie_ready1", {31'b0, req1_ready}, 32'd0);
      @(posedge clk); #1 req0_valid = 0;
      wait_rsp(0, 32'd2, 1'b0, 0, "tie_first");
      @(negedge clk);
      chk("loser_ready1", {31'b0, req1_ready}, 32'd1);
      @(posedge clk); #1 req1_valid = 0;
      wait_rsp(1, 32'hF0, 1'b0, 0, "tie_second");
    end

    // backpressure with the other port waiting
    issue(0, 32'hFFFF_FFFF, 32'd1, 3'b111);
    set_req(1, 32'h1234_5678, 32'h0000_FFFF, 3'b001);
    wait_rsp(0, 32'd1, 1'b0, 5, "bp_slt");
    @(negedge clk);
    chk("bp_next_ready1", {31'b0, req1_ready}, 32'd1);
    @(posedge clk); #1 req1_valid = 0;
    wait_rsp(1, 32'h1234_FFFF, 1'b0, 0, "bp_or");

    // reset during EXEC discards the operation
    issue(1, 32'd3, 32'd4, 3'b010);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_alu_a", alu_a, 32'd0);
    chk("post_rst_ctl", {29'b0, alu_control}, 32'd0);
    chk("post_rst_result", rsp1_result, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp1_valid) cnt++;
    end
    chk("discarded_rsp", cnt, 0);
    @(posedge clk); #1;
    issue(1, 32'd3, 32'd4, 3'b010);
    wait_rsp(1, 32'd7, 1'b0, 0, "after_rst");

    // randomized traffic, requests held stable until accepted
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      @(posedge clk); #1;
      if (h0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = rnd_operand(); req0_b = rnd_operand(); req0_op = 3'($urandom_range(0, 7));
      end
      if (h1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = rnd_operand(); req1_b = rnd_operand(); req1_op = 3'($urandom_range(0, 7));
      end
      rsp0_ready = $urandom_range(0, 1);
      rsp1_ready = $urandom_range(0, 1);
      reset = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; reset = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
